usb_uart_serial_bridge: RTL and testbench
=========================================

Name: usb_uart_serial_bridge

Overview:
Master for the byte-stream side of the USB CDC UART block. It drives that block's uart_we / uart_re / uart_di, and it consumes uart_do / uart_wait. Bytes read from USB are serialised onto a physical 8N1 TX pin. Bytes received on a physical 8N1 RX pin are written into USB. The block turns the USB serial device into a USB-to-UART dongle on the 48 MHz USB clock domain.

Parameters:
CLK_HZ, 48000000, clock frequency in Hz
BAUD, 115200, line rate
CLKS_PER_BIT, CLK_HZ/BAUD (416), bit period in clocks; must be >= 4

Ports:
clk_48mhz  input  1  single clock
resetn  input  1  asynchronous, active-low reset
uart_we  output  1  write request to USB block
uart_re  output  1  read request to USB block
uart_di  output  8  write data to USB block
uart_do  input  8  read data from USB block
uart_wait  input  1  high: current request not accepted this cycle
ser_tx  output  1  8N1 serial out, idle high
ser_rx  input  1  8N1 serial in, asynchronous
tx_busy  output  1  high while a TX frame is on the line
rx_overrun  output  1  1-cycle pulse: received byte dropped
rx_frame_err  output  1  1-cycle pulse: stop bit sampled low

Behaviour:
- Reset: resetn low forces state immediately, regardless of clock.
  - ser_tx=1; uart_we=0, uart_re=0, uart_di=0; tx_busy=0, rx_overrun=0, rx_frame_err=0.
  - Both FSMs go to IDLE; the holding register is emptied; the RX synchroniser is set to 1.
  - A frame in flight is abandoned. ser_tx returns high at once.
- Handshake rules:
  - A transfer completes in a cycle where its request is high and uart_wait=0.
  - uart_do is sampled in that same cycle.
  - uart_we and uart_re are never high in the same cycle.
  - A request may be withdrawn while uart_wait=1.
- RX path:
  - ser_rx passes through a 2-flop synchroniser.
  - States: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: a synchronised low moves to RX_START. The counter loads CLKS_PER_BIT/2.
  - RX_START: at count expiry, re-sample. If high, it is a glitch: return to RX_IDLE. If low, go to RX_DATA.
  - RX_DATA: sample 8 bits, LSB first, every CLKS_PER_BIT clocks.
  - RX_STOP: sample after CLKS_PER_BIT clocks.
    - Stop bit 1: the byte is delivered to the holding register.
    - Stop bit 0: pulse rx_frame_err and discard the byte.
    - Either way, return to RX_IDLE in the next cycle.
- Holding register (1 entry):
  - While valid: uart_we=1 and uart_di=held byte.
  - A write completion clears valid.
  - A byte delivered while valid, without completion in the same cycle: rx_overrun pulses, the new byte is dropped, the held byte is kept.
  - Completion and delivery in the same cycle: the new byte loads, no overrun.
- Latency: stop-sample cycle S -> uart_we high at S+1.
- TX path:
  - States: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE: uart_re=1 whenever uart_we=0. Write has priority.
  - Read completion: latch uart_do into the shift register and go to TX_START in the next cycle.
  - Frame timing, each phase CLKS_PER_BIT clocks: start bit (ser_tx=0), 8 data bits LSB first, stop bit (ser_tx=1).
  - After the stop bit, return to TX_IDLE.
  - tx_busy=1 in TX_START, TX_DATA and TX_STOP.
  - uart_re=0 outside TX_IDLE.
  - Read accepted at cycle N -> start bit driven from N+1.
  - Back-to-back bytes give zero idle gap beyond the one re-request cycle.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT). It wraps to reload and never free-runs past its bound.
  - Bit index is 3 bits, 0..7.
  - RX and TX are fully independent and may run simultaneously.

Test Plan:
1. Reset with resetn low -> ser_tx=1, all other outputs 0. Release with uart_wait=1 -> uart_re=1 next cycle, uart_we=0.
2. Read accepted with uart_do=0xA5 -> ser_tx sequence 0,1,0,1,0,0,1,0,1,1 at 416 clocks each. tx_busy high for exactly 4160 cycles. uart_re=0 during the frame, then 1 again after the stop bit.
3. Inject 0x3C on ser_rx at 416 clocks/bit, uart_wait=0 -> uart_we high for 1 cycle with uart_di=0x3C. No pulse on rx_overrun or rx_frame_err.
4. Overrun case:
   - Hold uart_wait=1 and inject 0x11 then 0x22 -> uart_we held with uart_di=0x11. rx_overrun pulses once at the 0x22 stop sample.
   - Drop uart_wait -> 0x11 is written once. 0x22 is never written.
5. Error cases:
   - Frame with stop bit 0 -> one rx_frame_err pulse, no uart_we.
   - 100-cycle low glitch on ser_rx -> ignored, no outputs change.
6. Reset and priority:
   - resetn low mid-data-bit of a TX frame -> ser_tx=1 immediately. After release the next read starts a clean frame.
   - Simultaneous RX holding byte and idle TX -> uart_we asserted, uart_re suppressed until the write completes.

Source files
------------

// File: rtl/usb_uart_serial_bridge_if.sv
// Byte-stream handshake between the USB CDC UART block and its master.
// A transfer completes in any cycle where its request is high and uart_wait is low.
interface usb_uart_serial_bridge_if;
   logic       uart_we;
   logic       uart_re;
   logic [7:0] uart_di;
   logic [7:0] uart_do;
   logic       uart_wait;

   modport master (
      output uart_we,
      output uart_re,
      output uart_di,
      input  uart_do,
      input  uart_wait
   );

   modport slave (
      input  uart_we,
      input  uart_re,
      input  uart_di,
      output uart_do,
      output uart_wait
   );
endinterface

// File: rtl/usb_uart_serial_bridge.sv
// USB-to-UART dongle core: USB reads become 8N1 frames on ser_tx, and 8N1 frames
// from ser_rx pass through a one-entry holding register into USB writes.
module usb_uart_serial_bridge #(
   parameter int unsigned CLK_HZ       = 48000000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
   input  logic                      clk_48mhz,
   input  logic                      resetn,
   usb_uart_serial_bridge_if.master  usb,
   output logic                      ser_tx,
   input  logic                      ser_rx,
   output logic                      tx_busy,
   output logic                      rx_overrun,
   output logic                      rx_frame_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   logic             rx_meta, rx_s;
   logic [1:0]       rx_state, rx_state_n;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]       rx_bit, rx_bit_n;
   logic [7:0]       rx_shift, rx_shift_n;
   logic             hold_valid, hold_valid_n;
   logic [7:0]       hold_byte, hold_byte_n;
   logic             rx_overrun_n, rx_frame_err_n;

   logic [1:0]       tx_state, tx_state_n;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]       tx_bit, tx_bit_n;
   logic [7:0]       tx_shift, tx_shift_n;
   logic             ser_tx_n, tx_busy_n;
   logic             re_q, re_n;

   logic             rx_deliver, wr_done, rd_done;

   assign usb.uart_we = hold_valid;
   assign usb.uart_di = hold_byte;
   assign usb.uart_re = re_q;

   // Next-state and registered-output logic for both line FSMs and the holding register
   always_comb begin
      rx_state_n     = rx_state;
      rx_cnt_n       = rx_cnt;
      rx_bit_n       = rx_bit;
      rx_shift_n     = rx_shift;
      hold_valid_n   = hold_valid;
      hold_byte_n    = hold_byte;
      rx_overrun_n   = 1'b0;
      rx_frame_err_n = 1'b0;
      tx_state_n     = tx_state;
      tx_cnt_n       = tx_cnt;
      tx_bit_n       = tx_bit;
      tx_shift_n     = tx_shift;
      ser_tx_n       = ser_tx;
      rx_deliver     = 1'b0;
      wr_done        = hold_valid & ~usb.uart_wait;
      rd_done        = re_q & ~usb.uart_wait;

      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_state_n = RX_START;
               rx_cnt_n   = CNT_HALF;
            end
         end
         RX_START: begin
            if (rx_cnt == '0) begin
               // Line back high at mid start bit: treat as a glitch
               if (rx_s) begin
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_state_n = RX_DATA;
                  rx_cnt_n   = CNT_FULL;
                  rx_bit_n   = 3'd0;
               end
            end else begin
               rx_cnt_n = rx_cnt - CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt == '0) begin
               rx_shift_n = {rx_s, rx_shift[7:1]};
               rx_cnt_n   = CNT_FULL;
               rx_bit_n   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) begin
                  rx_state_n = RX_STOP;
               end
            end else begin
               rx_cnt_n = rx_cnt - CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt == '0) begin
               rx_state_n = RX_IDLE;
               if (rx_s) begin
                  rx_deliver = 1'b1;
               end else begin
                  rx_frame_err_n = 1'b1;
               end
            end else begin
               rx_cnt_n = rx_cnt - CNT_ONE;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase

      // A same-cycle write completion frees the slot for the arriving byte
      if (rx_deliver && (!hold_valid || wr_done)) begin
         hold_valid_n = 1'b1;
         hold_byte_n  = rx_shift;
      end else if (rx_deliver) begin
         rx_overrun_n = 1'b1;
      end else if (wr_done) begin
         hold_valid_n = 1'b0;
      end

      case (tx_state)
         TX_IDLE: begin
            if (rd_done) begin
               tx_state_n = TX_START;
               tx_shift_n = usb.uart_do;
               tx_cnt_n   = CNT_FULL;
               ser_tx_n   = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt == '0) begin
               tx_state_n = TX_DATA;
               tx_cnt_n   = CNT_FULL;
               tx_bit_n   = 3'd0;
               ser_tx_n   = tx_shift[0];
               tx_shift_n = {1'b0, tx_shift[7:1]};
            end else begin
               tx_cnt_n = tx_cnt - CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt == '0) begin
               tx_cnt_n = CNT_FULL;
               if (tx_bit == 3'd7) begin
                  tx_state_n = TX_STOP;
                  ser_tx_n   = 1'b1;
               end else begin
                  tx_bit_n   = tx_bit + 3'd1;
                  ser_tx_n   = tx_shift[0];
                  tx_shift_n = {1'b0, tx_shift[7:1]};
               end
            end else begin
               tx_cnt_n = tx_cnt - CNT_ONE;
            end
         end
         TX_STOP: begin
            if (tx_cnt == '0) begin
               tx_state_n = TX_IDLE;
            end else begin
               tx_cnt_n = tx_cnt - CNT_ONE;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase

      tx_busy_n = (tx_state_n != TX_IDLE);
      // Pending USB write always wins over a new read
      re_n      = (tx_state_n == TX_IDLE) && !hold_valid_n;
   end

   // State and output registers; the RX synchroniser idles high
   always_ff @(posedge clk_48mhz or negedge resetn) begin
      if (!resetn) begin
         rx_meta      <= 1'b1;
         rx_s         <= 1'b1;
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         hold_valid   <= 1'b0;
         hold_byte    <= '0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
         tx_state     <= TX_IDLE;
         tx_cnt       <= '0;
         tx_bit       <= '0;
         tx_shift     <= '0;
         ser_tx       <= 1'b1;
         tx_busy      <= 1'b0;
         re_q         <= 1'b0;
      end else begin
         rx_meta      <= ser_rx;
         rx_s         <= rx_meta;
         rx_state     <= rx_state_n;
         rx_cnt       <= rx_cnt_n;
         rx_bit       <= rx_bit_n;
         rx_shift     <= rx_shift_n;
         hold_valid   <= hold_valid_n;
         hold_byte    <= hold_byte_n;
         rx_overrun   <= rx_overrun_n;
         rx_frame_err <= rx_frame_err_n;
         tx_state     <= tx_state_n;
         tx_cnt       <= tx_cnt_n;
         tx_bit       <= tx_bit_n;
         tx_shift     <= tx_shift_n;
         ser_tx       <= ser_tx_n;
         tx_busy      <= tx_busy_n;
         re_q         <= re_n;
      end
   end

endmodule

// File: tb/tb_usb_uart_serial_bridge.sv
// Bench for usb_uart_serial_bridge: directed scenarios plus randomized traffic,
// checked each cycle against a frame-level model of the bridge.
module tb_usb_uart_serial_bridge;
   localparam int CPB = 416;
   localparam int H   = CPB / 2;
   // Stop-bit sample cycle relative to the edge that drives the start bit low:
   // two synchroniser flops, one detect cycle, half a bit, then nine full bits.
   localparam int STOP_SAMPLE = 3 + H + 9 * CPB;

   logic clk_48mhz = 1'b0;
   logic resetn    = 1'b1;
   logic ser_rx    = 1'b1;
   logic ser_tx, tx_busy, rx_overrun, rx_frame_err;

   usb_uart_serial_bridge_if usb ();

   usb_uart_serial_bridge dut (
      .clk_48mhz    (clk_48mhz),
      .resetn       (resetn),
      .usb          (usb),
      .ser_tx       (ser_tx),
      .ser_rx       (ser_rx),
      .tx_busy      (tx_busy),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   int cyc = 0;
   always @(posedge clk_48mhz) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   // Injected RX frames: written only by the stimulus, consumed by the model
   int         ev_e [64];
   logic [7:0] ev_b [64];
   bit         ev_s [64];
   int         ev_wr = 0;
   int         ev_rd = 0;

   // Model state
   bit         m_tx_act = 1'b0;
   int         m_tx_n   = 0;
   logic [7:0] m_tx_byte = 8'h00;
   bit         m_hold_v = 1'b0;
   logic [7:0] m_hold_b = 8'h00;
   bit         m_ovr = 1'b0, m_ferr = 1'b0, m_fresh = 1'b1;

   // Observation totals (read-only for the stimulus)
   int         ovr_tot = 0, ferr_tot = 0, busy_tot = 0, we_tot = 0;
   logic [7:0] wr_log [$];

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   // Per-cycle compare against the model, then advance the model
   always @(negedge clk_48mhz) begin
      bit         tx_act, exp_re, wr, rd, deliver, bad;
      logic [7:0] nb;
      if (!resetn) begin
         chk("rst_ser_tx", 32'(ser_tx), 32'd1);
         chk("rst_we", 32'(usb.uart_we), 32'd0);
         chk("rst_re", 32'(usb.uart_re), 32'd0);
         chk("rst_di", 32'(usb.uart_di), 32'd0);
         chk("rst_busy", 32'(tx_busy), 32'd0);
         chk("rst_ovr", 32'(rx_overrun), 32'd0);
         chk("rst_ferr", 32'(rx_frame_err), 32'd0);
         m_tx_act = 1'b0;
         m_hold_v = 1'b0;
         m_ovr    = 1'b0;
         m_ferr   = 1'b0;
         m_fresh  = 1'b1;
         ev_rd    = ev_wr;
      end else begin
         if (m_tx_act && cyc > m_tx_n + 10 * CPB) m_tx_act = 1'b0;
         tx_act = m_tx_act && (cyc >= m_tx_n + 1);
         exp_re = !tx_act && !m_hold_v && !m_fresh;
         chk("ser_tx", 32'(ser_tx),
             32'(tx_act ? frame_bit(m_tx_byte, (cyc - m_tx_n - 1) / CPB) : 1'b1));
         chk("tx_busy", 32'(tx_busy), 32'(tx_act));
         chk("uart_we", 32'(usb.uart_we), 32'(m_hold_v));
         if (m_hold_v) chk("uart_di", 32'(usb.uart_di), 32'(m_hold_b));
         chk("uart_re", 32'(usb.uart_re), 32'(exp_re));
         chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
         chk("rx_frame_err", 32'(rx_frame_err), 32'(m_ferr));

         if (rx_overrun) ovr_tot++;
         if (rx_frame_err) ferr_tot++;
         if (tx_busy) busy_tot++;
         if (usb.uart_we) we_tot++;
         if (usb.uart_we && !usb.uart_wait) wr_log.push_back(usb.uart_di);

         m_fresh = 1'b0;
         wr      = m_hold_v && !usb.uart_wait;
         rd      = exp_re && !usb.uart_wait;
         deliver = 1'b0;
         bad     = 1'b0;
         nb      = 8'h00;
         if (ev_rd < ev_wr && ev_e[ev_rd] == cyc) begin
            nb = ev_b[ev_rd];
            if (ev_s[ev_rd]) deliver = 1'b1;
            else bad = 1'b1;
            ev_rd++;
         end
         m_ovr  = 1'b0;
         m_ferr = bad;
         if (deliver && (!m_hold_v || wr)) begin
            m_hold_v = 1'b1;
            m_hold_b = nb;
         end else if (deliver) begin
            m_ovr = 1'b1;
         end else if (wr) begin
            m_hold_v = 1'b0;
         end
         if (rd) begin
            m_tx_act  = 1'b1;
            m_tx_n    = cyc;
            m_tx_byte = usb.uart_do;
         end
      end
   end

   bit rand_mode = 1'b0;

   task automatic step();
      @(posedge clk_48mhz);
      #1;
      if (rand_mode) begin
         usb.uart_do = 8'($urandom);
         if ($urandom_range(0, 1499) == 0) usb.uart_wait = ~usb.uart_wait;
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic at_cycle(input int t);
      do @(negedge clk_48mhz); while (cyc < t);
   endtask

   task automatic send_rx(input logic [7:0] b, input bit stop, input int gap);
      step();
      ser_rx = 1'b0;
      ev_e[ev_wr] = cyc + STOP_SAMPLE;
      ev_b[ev_wr] = b;
      ev_s[ev_wr] = stop;
      ev_wr++;
      steps(CPB);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         steps(CPB);
      end
      ser_rx = stop;
      steps(CPB);
      ser_rx = 1'b1;
      steps(gap);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (tx_busy && k < 6000) begin
         step();
         k++;
      end
      chk("tx_idle_timeout", 32'(tx_busy), 32'd0);
   endtask

   function automatic int wr_count(input int from, input logic [7:0] b);
      int c = 0;
      for (int i = from; i < wr_log.size(); i++) if (wr_log[i] == b) c++;
      return c;
   endfunction

   initial begin
      #(160000 * 10);
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic seq_a5 [10];
      int n, b0, w0, o0, f0, we0;
      seq_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      usb.uart_wait = 1'b1;
      usb.uart_do   = 8'h00;
      #2 resetn = 1'b0;

      // Reset values and first request after release
      steps(3);
      chk("reset_ser_tx", 32'(ser_tx), 32'd1);
      chk("reset_we", 32'(usb.uart_we), 32'd0);
      chk("reset_re", 32'(usb.uart_re), 32'd0);
      resetn = 1'b1;
      step();
      chk("re_after_release", 32'(usb.uart_re), 32'd1);
      chk("we_after_release", 32'(usb.uart_we), 32'd0);

      // TX frame of 0xA5
      step();
      usb.uart_do   = 8'hA5;
      usb.uart_wait = 1'b0;
      n  = cyc;
      b0 = busy_tot;
      step();
      usb.uart_wait = 1'b1;
      for (int k = 0; k < 10; k++) begin
         at_cycle(n + 1 + k * CPB + H);
         chk("a5_bit", 32'(ser_tx), 32'(seq_a5[k]));
         if (k == 4) chk("a5_re_low", 32'(usb.uart_re), 32'd0);
      end
      at_cycle(n + 10 * CPB + 3);
      chk("a5_busy_cycles", 32'(busy_tot - b0), 32'd4160);
      chk("a5_re_again", 32'(usb.uart_re), 32'd1);

      // RX byte 0x3C with no backpressure
      usb.uart_do   = 8'h00;
      usb.uart_wait = 1'b0;
      w0 = wr_log.size(); o0 = ovr_tot; f0 = ferr_tot; we0 = we_tot;
      send_rx(8'h3C, 1'b1, 100);
      chk("3c_we_cycles", 32'(we_tot - we0), 32'd1);
      chk("3c_writes", 32'(wr_log.size() - w0), 32'd1);
      chk("3c_data", 32'(wr_count(w0, 8'h3C)), 32'd1);
      chk("3c_no_ovr", 32'(ovr_tot - o0), 32'd0);
      chk("3c_no_ferr", 32'(ferr_tot - f0), 32'd0);

      // Overrun: second byte arrives while the first is still held
      usb.uart_wait = 1'b1;
      w0 = wr_log.size(); o0 = ovr_tot;
      send_rx(8'h11, 1'b1, 20);
      send_rx(8'h22, 1'b1, 20);
      @(negedge clk_48mhz);
      chk("ovr_we_held", 32'(usb.uart_we), 32'd1);
      chk("ovr_di_held", 32'(usb.uart_di), 32'h11);
      chk("ovr_pulses", 32'(ovr_tot - o0), 32'd1);
      step();
      usb.uart_wait = 1'b0;
      steps(10);
      chk("ovr_11_written", 32'(wr_count(w0, 8'h11)), 32'd1);
      chk("ovr_22_dropped", 32'(wr_count(w0, 8'h22)), 32'd0);

      // Bad stop bit, then a short low glitch
      w0 = wr_log.size(); f0 = ferr_tot; o0 = ovr_tot;
      send_rx(8'h5A, 1'b0, 2 * CPB);
      chk("ferr_pulses", 32'(ferr_tot - f0), 32'd1);
      chk("ferr_no_write", 32'(wr_log.size() - w0), 32'd0);
      ser_rx = 1'b0;
      steps(100);
      ser_rx = 1'b1;
      steps(2 * CPB);
      chk("glitch_no_write", 32'(wr_log.size() - w0), 32'd0);
      chk("glitch_no_ferr", 32'(ferr_tot - f0), 32'd1);
      chk("glitch_no_ovr", 32'(ovr_tot - o0), 32'd0);

      // Reset in the middle of a TX data bit
      usb.uart_wait = 1'b1;
      wait_idle();
      step();
      chk("pre_abort_re", 32'(usb.uart_re), 32'd1);
      usb.uart_do   = 8'hC3;
      usb.uart_wait = 1'b0;
      n = cyc;
      step();
      usb.uart_wait = 1'b1;
      at_cycle(n + 1 + 3 * CPB + 100);
      chk("abort_mid_bit_low", 32'(ser_tx), 32'd0);
      #2 resetn = 1'b0;
      #1;
      chk("abort_ser_tx_high", 32'(ser_tx), 32'd1);
      chk("abort_busy_low", 32'(tx_busy), 32'd0);
      steps(3);
      resetn = 1'b1;
      steps(2);
      usb.uart_do   = 8'h81;
      usb.uart_wait = 1'b0;
      b0 = busy_tot;
      step();
      usb.uart_wait = 1'b1;
      steps(10 * CPB + 5);
      chk("clean_frame_busy", 32'(busy_tot - b0), 32'd4160);

      // Held RX byte suppresses reads from an idle TX
      w0 = wr_log.size();
      send_rx(8'h96, 1'b1, 50);
      @(negedge clk_48mhz);
      chk("prio_we", 32'(usb.uart_we), 32'd1);
      chk("prio_re", 32'(usb.uart_re), 32'd0);
      chk("prio_di", 32'(usb.uart_di), 32'h96);
      step();
      usb.uart_wait = 1'b0;
      steps(3);
      chk("prio_written", 32'(wr_count(w0, 8'h96)), 32'd1);

      // Randomized traffic in both directions
      rand_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic [7:0] rb;
         bit         rs;
         rb = 8'($urandom);
         rs = ($urandom_range(0, 5) != 0);
         send_rx(rb, rs, $urandom_range(0, CPB) + (rs ? 0 : 2 * CPB));
      end
      rand_mode = 1'b0;
      usb.uart_wait = 1'b0;
      steps(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
